cordic_sched: RTL
=================

CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
REQ-001 Parameter WIDTH, default 32, datapath word width (signed fixed point).
REQ-002 Parameter FPSHIFT, default 28, fractional bits of angle/sine/cosine (Q4.28 radians).
REQ-003 Parameter LATENCY, default 32, cycles from stable cor_angle to valid cor_sine/cor_cosine; legal range 1..255.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req0_valid / req1_valid  in  1  requester n has an angle pending.
REQ-007 req0_angle / req1_angle  in  WIDTH  unsigned angle, legal range [0, 4*pi).
REQ-008 req0_ready / req1_ready  out  1  angle accepted this cycle when valid&ready.
REQ-009 rsp_valid  out  1; rsp_id  out  1 (requester index); rsp_sine / rsp_cosine  out  WIDTH signed; rsp_ready  in  1.
REQ-010 cor_angle  out  WIDTH  folded angle driven to the shared CORDIC core; cor_sine / cor_cosine  in  WIDTH  core results.
REQ-011 busy  out  1  high in any state except IDLE.

Function
REQ-012 FSM states IDLE, ISSUE, WAIT, DONE; IDLE->ISSUE on accept; ISSUE->WAIT next cycle; WAIT->DONE when counter reaches 0; DONE->IDLE on rsp_valid&rsp_ready.
REQ-013 In IDLE, readyN SHALL be high only for the granted requester; at most one ready high per cycle; both low outside IDLE.
REQ-014 Grant: round-robin, 1-bit pointer; single valid wins; both valid -> pointer side wins; after accept pointer = other requester.
REQ-015 Range reduction at accept: a >= 2*pi -> a - 2*pi (single subtraction); record quadrant q from a vs pi/2, pi, 3*pi/2.
REQ-016 Folding: q0 f=a; q1 f=pi-a; q2 f=a-pi; q3 f=2*pi-a; cor_angle=f registered in ISSUE, held constant through WAIT and DONE.
REQ-017 WAIT counter loads LATENCY-1 on ISSUE->WAIT, decrements each WAIT cycle; results captured on the cycle it reads 0.
REQ-018 Sign fix at capture: q0 (+s,+c); q1 (+s,-c); q2 (-s,-c); q3 (-s,+c); two's-complement negation, no saturation needed (|value| <= 1.0).
REQ-019 Accept-to-rsp_valid latency exactly LATENCY+2 cycles; rsp_* held stable while rsp_valid&!rsp_ready.
REQ-020 Angles >= 4*pi are out of contract; block SHALL still complete the handshake (no hang), result undefined.
REQ-021 rsp_valid&rsp_ready and a new valid in same cycle: new accept occurs no earlier than next cycle (IDLE).

Reset
REQ-022 rst_n low: state IDLE, pointer 0, counter 0, cor_angle 0, rsp_valid 0, rsp_id 0, rsp_sine/rsp_cosine 0, both ready 0 during reset.
REQ-023 Reset mid-operation aborts the transaction; no response is ever produced for it.
REQ-024 First accept allowed in the first cycle after rst_n deasserts.

Structure
REQ-025 Shared package cordic_pkg holds FP constants PI_2, PI, PI3_2, TWO_PI at FPSHIFT, plus state enum and quadrant type.
REQ-026 One sub-module natural: cordic_fold (combinational angle reduction + quadrant); CORDIC core stays external to this block.

Verification
REQ-027 req0 angle 0x0C90FDAA (45 deg), core model LATENCY 32 -> rsp_valid at cycle 34, sine ~0x0B504F33, cosine ~0x0B504F33 (+/-16 LSB), rsp_id 0.
REQ-028 req1 angle 0x25B2F8FE (135 deg) -> cor_angle 0x0C90FDAA, sine ~+0x0B504F33, cosine ~-0x0B504F33, rsp_id 1.
REQ-029 Both valid continuously, 6 transactions -> grants alternate 0,1,0,1,0,1; never two readys in one cycle.
REQ-030 rsp_ready low 10 cycles in DONE -> rsp_* stable, busy high, no new ready until handshake.
REQ-031 Angle 0x6487ED51+0x0C90FDAA (2*pi+45 deg) -> same result as 45 deg; angle 0 -> sine ~0, cosine ~0x10000000.
REQ-032 rst_n pulsed low mid-WAIT -> all outputs reset values immediately, no rsp_valid afterwards, next request served normally.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC request scheduler.
// Angle constants are kept at 60 fractional bits and scaled down by fp_const
// to whatever fractional width the datapath uses (truncation, not rounding).
package cordic_pkg;

  // pi/2, pi, 3pi/2 and 2pi with 60 fractional bits
  localparam logic [63:0] PI_2   = 64'h1921FB54442D1846;
  localparam logic [63:0] PI     = 64'h3243F6A8885A308D;
  localparam logic [63:0] PI3_2  = 64'h4B65F1FCCC8748D2;
  localparam logic [63:0] TWO_PI = 64'h6487ED5110B4611A;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_t;

  // Rescale a 60-fraction-bit constant to 'shift' fractional bits.
  function automatic logic [63:0] fp_const(input logic [63:0] q60, input int shift);
    return q60 >> (60 - shift);
  endfunction

endpackage

// File: rtl/cordic_fold.sv
// Combinational angle reduction: one 2*pi subtraction, then quadrant detect
// and fold into [0, pi/2] for the CORDIC core.
// Ports: angle_i (unsigned, fixed point), fold_o (folded angle), quad_o (quadrant).
module cordic_fold
  import cordic_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FPSHIFT = 28
) (
  input  logic [WIDTH-1:0] angle_i,
  output logic [WIDTH-1:0] fold_o,
  output quad_t            quad_o
);

  localparam logic [63:0] K_PI_2   = fp_const(PI_2, FPSHIFT);
  localparam logic [63:0] K_PI     = fp_const(PI, FPSHIFT);
  localparam logic [63:0] K_PI3_2  = fp_const(PI3_2, FPSHIFT);
  localparam logic [63:0] K_TWO_PI = fp_const(TWO_PI, FPSHIFT);

  localparam logic [WIDTH-1:0] C_PI_2   = K_PI_2[WIDTH-1:0];
  localparam logic [WIDTH-1:0] C_PI     = K_PI[WIDTH-1:0];
  localparam logic [WIDTH-1:0] C_PI3_2  = K_PI3_2[WIDTH-1:0];
  localparam logic [WIDTH-1:0] C_TWO_PI = K_TWO_PI[WIDTH-1:0];

  logic [WIDTH-1:0] red;

  always_comb begin
    red = angle_i;
    // Legal inputs are below 4*pi, so a single subtraction lands in [0, 2*pi).
    if (angle_i >= C_TWO_PI) red = angle_i - C_TWO_PI;

    quad_o = Q0;
    fold_o = red;
    if (red < C_PI_2) begin
      quad_o = Q0;
      fold_o = red;
    end else if (red < C_PI) begin
      quad_o = Q1;
      fold_o = C_PI - red;
    end else if (red < C_PI3_2) begin
      quad_o = Q2;
      fold_o = red - C_PI;
    end else begin
      quad_o = Q3;
      fold_o = C_TWO_PI - red;
    end
  end

endmodule

// File: rtl/cordic_sched.sv
// Two-requester front end for a shared external CORDIC core: round-robin grant,
// range reduction/folding, fixed-latency wait, quadrant sign fix, held response.
// Ports: reqN_valid/angle/ready (requests), rsp_* (response, valid/ready),
//        cor_angle/cor_sine/cor_cosine (core), busy (not idle).
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FPSHIFT = 28,
  parameter int LATENCY = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_angle,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_angle,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sine,
  output logic [WIDTH-1:0] rsp_cosine,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] cor_angle,
  input  logic [WIDTH-1:0] cor_sine,
  input  logic [WIDTH-1:0] cor_cosine,
  output logic             busy
);

  state_t           state_q;
  logic             ptr_q;
  logic             id_q;
  quad_t            quad_q;
  logic [WIDTH-1:0] fold_q;
  logic [7:0]       cnt_q;
  logic [WIDTH-1:0] cor_angle_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_sine_q;
  logic [WIDTH-1:0] rsp_cosine_q;

  logic             gnt0_d, gnt1_d, idle_d;
  logic [WIDTH-1:0] sel_angle_d, fold_d;
  quad_t            quad_d;

  // Pointer only matters when both requesters are valid.
  always_comb begin
    gnt0_d      = req0_valid && (!req1_valid || !ptr_q);
    gnt1_d      = req1_valid && (!req0_valid || ptr_q);
    sel_angle_d = gnt1_d ? req1_angle : req0_angle;
  end

  cordic_fold #(
    .WIDTH  (WIDTH),
    .FPSHIFT(FPSHIFT)
  ) u_fold (
    .angle_i(sel_angle_d),
    .fold_o (fold_d),
    .quad_o (quad_d)
  );

  // Gated by rst_n so neither ready is seen while reset is held.
  assign idle_d     = (state_q == S_IDLE) && rst_n;
  assign req0_ready = idle_d && gnt0_d;
  assign req1_ready = idle_d && gnt1_d;
  assign busy       = (state_q != S_IDLE);
  assign cor_angle  = cor_angle_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_sine   = rsp_sine_q;
  assign rsp_cosine = rsp_cosine_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= 1'b0;
      id_q         <= 1'b0;
      quad_q       <= Q0;
      fold_q       <= '0;
      cnt_q        <= '0;
      cor_angle_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_sine_q   <= '0;
      rsp_cosine_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt0_d || gnt1_d) begin
            fold_q  <= fold_d;
            quad_q  <= quad_d;
            id_q    <= gnt1_d;
            ptr_q   <= !gnt1_d;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cor_angle_q <= fold_q;
          cnt_q       <= 8'(LATENCY - 1);
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == 8'd0) begin
            // Undo the fold: sine negative in Q2/Q3, cosine negative in Q1/Q2.
            rsp_sine_q   <= (quad_q == Q2 || quad_q == Q3) ? -cor_sine : cor_sine;
            rsp_cosine_q <= (quad_q == Q1 || quad_q == Q2) ? -cor_cosine : cor_cosine;
            rsp_id_q     <= id_q;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
